// File: rtl/parser_pkg.sv
// Shared parser field geometry: key/type counts, offset widths and shift widths
// used by every parser stage.
package parser_pkg;

  localparam int KEY_FILED_NUM     = 2;
  localparam int KEY_OFFSET_WIDTH  = 6;
  localparam int TYPE_NUM          = 2;
  localparam int TYPE_WIDTH        = 16;
  localparam int TYPE_OFFSET_WIDTH = 6;
  localparam int HEAD_SHIFT_WIDTH  = 7;
  localparam int META_SHIFT_WIDTH  = 6;

  typedef logic [KEY_OFFSET_WIDTH:0] key_off_t;

endpackage

// File: rtl/byte_window_extract.sv
// Returns OUT_BYTES bytes of a big-endian byte vector starting at a byte
// offset; bytes beyond the end of the data read as zero.
module byte_window_extract #(
  parameter int DATA_BYTES = 64,
  parameter int OUT_BYTES  = 2,
  parameter int OFF_W      = 6
) (
  input  logic [DATA_BYTES*8-1:0] data_i,
  input  logic [OFF_W-1:0]        offset_i,
  output logic [OUT_BYTES*8-1:0]  win_o
);

  logic [OFF_W+2:0] bit_off_s;

  assign bit_off_s = {offset_i, 3'b000};
  // Left shift drops the leading bytes and zero-fills; the window is the top slice.
  assign win_o = (OUT_BYTES*8)'((data_i << bit_off_s) >> ((DATA_BYTES - OUT_BYTES) * 8));

endmodule

// File: rtl/parser_extract_stage.sv
// Two-stage parser pipeline: S1 extracts keys into metadata, S2 shifts the
// header and picks next-stage types. Optional counters: PARSER_STAGE_STATS_EN.
module parser_extract_stage
  import parser_pkg::*;
#(
  parameter int HEAD_BYTES = 64,
  parameter int META_BYTES = 32,
  parameter int KEY_BYTES  = 2
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_valid,
  output logic                                       o_ready,
  input  logic [HEAD_BYTES*8-1:0]                    i_head,
  input  logic [META_BYTES*8-1:0]                    i_meta,
  input  logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0] i_keyOffset,
  input  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] i_typeOffset,
  input  logic [HEAD_SHIFT_WIDTH-1:0]                i_headShift,
  input  logic [META_SHIFT_WIDTH-1:0]                i_metaShift,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [HEAD_BYTES*8-1:0]                    o_head,
  output logic [META_BYTES*8-1:0]                    o_meta,
  output logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]        o_type
`ifdef PARSER_STAGE_STATS_EN
  ,
  output logic [31:0]                                o_pkt_cnt,
  output logic [31:0]                                o_nokey_cnt
`endif
);

  localparam int HW       = HEAD_BYTES * 8;
  localparam int MW       = META_BYTES * 8;
  localparam int KB       = KEY_BYTES * 8;
  localparam int KEY_BITS = KEY_FILED_NUM * KB;
  localparam logic [MW-1:0] KEY_MASK = MW'({KEY_BITS{1'b1}});

  logic                                       s1_valid_q, s2_valid_q, advance_s1;
  logic [KEY_FILED_NUM-1:0][KB-1:0]           key_raw_s;
  logic [KEY_BITS-1:0]                        key_vec_s;
  logic [MW-1:0]                              meta_sh_s, meta_d, s1_meta_q, s2_meta_q;
  logic [HW-1:0]                              s1_head_q, head_sh_s, s2_head_q;
  logic [HEAD_SHIFT_WIDTH-1:0]                s1_head_shift_q;
  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] s1_type_off_q;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]        type_s, s2_type_q;

  assign advance_s1 = ~s2_valid_q | i_ready;
  assign o_ready    = ~s1_valid_q | advance_s1;

  for (genvar k = 0; k < KEY_FILED_NUM; k++) begin : g_key
    byte_window_extract #(.DATA_BYTES(HEAD_BYTES), .OUT_BYTES(KEY_BYTES), .OFF_W(KEY_OFFSET_WIDTH)) u_key (
      .data_i   (i_head),
      .offset_i (i_keyOffset[k][KEY_OFFSET_WIDTH-1:0]),
      .win_o    (key_raw_s[k])
    );
  end

  // Key 0 lands in the most significant of the low key bytes.
  always_comb begin
    key_vec_s = '0;
    for (int k = 0; k < KEY_FILED_NUM; k++) begin
      if (i_keyOffset[k][KEY_OFFSET_WIDTH]) begin
        key_vec_s[KEY_BITS-1-k*KB -: KB] = key_raw_s[k];
      end else begin
        key_vec_s[KEY_BITS-1-k*KB -: KB] = '0;
      end
    end
  end

  byte_window_extract #(.DATA_BYTES(META_BYTES), .OUT_BYTES(META_BYTES), .OFF_W(META_SHIFT_WIDTH)) u_meta (
    .data_i   (i_meta),
    .offset_i (i_metaShift),
    .win_o    (meta_sh_s)
  );

  assign meta_d = (meta_sh_s & ~KEY_MASK) | MW'(key_vec_s);

  byte_window_extract #(.DATA_BYTES(HEAD_BYTES), .OUT_BYTES(HEAD_BYTES), .OFF_W(HEAD_SHIFT_WIDTH)) u_head (
    .data_i   (s1_head_q),
    .offset_i (s1_head_shift_q),
    .win_o    (head_sh_s)
  );

  for (genvar t = 0; t < TYPE_NUM; t++) begin : g_type
    byte_window_extract #(.DATA_BYTES(HEAD_BYTES), .OUT_BYTES(TYPE_WIDTH/8), .OFF_W(TYPE_OFFSET_WIDTH)) u_type (
      .data_i   (head_sh_s),
      .offset_i (s1_type_off_q[t]),
      .win_o    (type_s[t])
    );
  end

  // Pipeline occupancy; reset discards any in-flight beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (o_ready) s1_valid_q <= i_valid;
      if (advance_s1) s2_valid_q <= s1_valid_q;
    end
  end

  // Data registers load only on a transfer, so stalled outputs hold.
  always_ff @(posedge i_clk) begin
    if (i_valid && o_ready) begin
      s1_head_q       <= i_head;
      s1_meta_q       <= meta_d;
      s1_head_shift_q <= i_headShift;
      s1_type_off_q   <= i_typeOffset;
    end
    if (s1_valid_q && advance_s1) begin
      s2_head_q <= head_sh_s;
      s2_meta_q <= s1_meta_q;
      s2_type_q <= type_s;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_head  = s2_head_q;
  assign o_meta  = s2_meta_q;
  assign o_type  = s2_type_q;

`ifdef PARSER_STAGE_STATS_EN
  logic [KEY_FILED_NUM-1:0] key_vld_s;
  logic                     s1_nokey_q, s2_nokey_q;
  logic [31:0]              pkt_cnt_q, nokey_cnt_q;

  for (genvar k = 0; k < KEY_FILED_NUM; k++) begin : g_vld
    assign key_vld_s[k] = i_keyOffset[k][KEY_OFFSET_WIDTH];
  end

  // No-key flag travels alongside its beat.
  always_ff @(posedge i_clk) begin
    if (i_valid && o_ready) s1_nokey_q <= ~|key_vld_s;
    if (s1_valid_q && advance_s1) s2_nokey_q <= s1_nokey_q;
  end

  // Counters wrap naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q   <= 32'd0;
      nokey_cnt_q <= 32'd0;
    end else if (s2_valid_q && i_ready) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (s2_nokey_q) nokey_cnt_q <= nokey_cnt_q + 32'd1;
    end
  end

  assign o_pkt_cnt   = pkt_cnt_q;
  assign o_nokey_cnt = nokey_cnt_q;
`endif

endmodule
